// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode set, beat select encoding and the
// output-stage FSM state type used by the z result write-back path.
package alu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic ZLO = 1'b0;
  localparam logic ZHI = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } z_state_t;

  // Only mul/div produce a full 64-bit result needing an HI beat.
  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_fifo.sv
// Circular buffer of DEPTH entries ({wide, z}) with registered count.
// Head entry is read asynchronously so a push is visible the next cycle.
module z_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/z_result_stage.sv
// Buffers ALU z results and serialises them as LO/HI beats on the bus.
// Optional z_zero/z_neg flags are enabled with `define Z_RESULT_FLAGS_EN.
module z_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  zin_valid,
  output logic                  zin_ready,
  input  logic [2*DATA_W-1:0]   z_in,
  input  logic [4:0]            opcode,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [DATA_W-1:0]     beat_data,
  output logic                  beat_sel,
  output logic                  beat_last
`ifdef Z_RESULT_FLAGS_EN
  ,
  output logic                  z_zero,
  output logic                  z_neg
`endif
);

  localparam int EW = 2*DATA_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  z_state_t              state_reg;
  z_state_t              state_next;
  logic                  push;
  logic                  pop;
  logic                  beat_hs;
  logic [EW-1:0]         head;
  logic                  head_wide;
  logic [2*DATA_W-1:0]   head_z;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_after;
  logic                  full;
  logic                  empty;

  z_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data ({is_wide(opcode), z_in}),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign head_wide   = head[EW-1];
  assign head_z      = head[EW-2:0];
  assign zin_ready   = !full;
  assign push        = zin_valid && !full;
  assign beat_hs     = (state_reg != EMPTY) && beat_ready;
  // A wide head is only released after its HI beat.
  assign pop         = beat_hs && !empty && ((state_reg == HI) || !head_wide);
  assign count_after = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_reg <= EMPTY;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_sel   = ZLO;
    beat_last  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (push) state_next = LO;
      end
      LO: begin
        beat_valid = 1'b1;
        beat_data  = head_z[DATA_W-1:0];
        beat_last  = !head_wide;
        if (beat_hs) begin
          if (head_wide)               state_next = HI;
          else if (count_after != '0)  state_next = LO;
          else                         state_next = EMPTY;
        end
      end
      HI: begin
        beat_valid = 1'b1;
        beat_data  = head_z[2*DATA_W-1:DATA_W];
        beat_sel   = ZHI;
        beat_last  = 1'b1;
        if (beat_hs) state_next = (count_after != '0) ? LO : EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

`ifdef Z_RESULT_FLAGS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_zero <= 1'b0;
      z_neg  <= 1'b0;
    end else if (pop) begin
      z_zero <= head_wide ? (head_z == '0) : (head_z[DATA_W-1:0] == '0);
      z_neg  <= head_wide ? head_z[2*DATA_W-1] : head_z[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Self-checking bench for z_result_stage: queue-based result model checked
// every cycle, plus directed literal checks and randomized traffic.
module tb_z_result_stage;

  localparam int DEPTH = 2;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          zin_valid = 1'b0;
  logic          zin_ready;
  logic [63:0]   z_in = '0;
  logic [4:0]    opcode = '0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [DW-1:0] beat_data;
  logic          beat_sel;
  logic          beat_last;
`ifdef Z_RESULT_FLAGS_EN
  logic          z_zero;
  logic          z_neg;
`endif

  z_result_stage #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk        (clk),
    .clr        (clr),
    .zin_valid  (zin_valid),
    .zin_ready  (zin_ready),
    .z_in       (z_in),
    .opcode     (opcode),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_data  (beat_data),
    .beat_sel   (beat_sel),
    .beat_last  (beat_last)
`ifdef Z_RESULT_FLAGS_EN
    ,
    .z_zero     (z_zero),
    .z_neg      (z_neg)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending results plus which half of the head is on the bus.
  typedef struct {
    logic [63:0] z;
    bit          wide;
  } ent_t;

  ent_t q[$];
  int   half = 0;
  bit   m_zero = 0;
  bit   m_neg  = 0;

  initial begin
    forever begin
      bit   was_ready;
      ent_t e;
      @(posedge clk or negedge clr);
      if (!clr) begin
        q.delete();
        half   = 0;
        m_zero = 0;
        m_neg  = 0;
      end else begin
        was_ready = (q.size() < DEPTH);
        if (q.size() > 0 && beat_ready) begin
          if (half == 0 && q[0].wide) begin
            half = 1;
          end else begin
            e      = q.pop_front();
            half   = 0;
            m_zero = e.wide ? (e.z == 64'd0) : (e.z[31:0] == 32'd0);
            m_neg  = e.wide ? e.z[63] : e.z[31];
          end
        end
        if (zin_valid && was_ready) begin
          e.z    = z_in;
          e.wide = (opcode == 5'd15) || (opcode == 5'd16);
          q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      logic [63:0] exp_data;
      @(negedge clk);
      if (!clr) begin
        check("rst_zin_ready", zin_ready, 64'd1);
        check("rst_beat_valid", beat_valid, 64'd0);
        check("rst_beat_data", beat_data, 64'd0);
        check("rst_beat_sel", beat_sel, 64'd0);
        check("rst_beat_last", beat_last, 64'd0);
`ifdef Z_RESULT_FLAGS_EN
        check("rst_z_zero", z_zero, 64'd0);
        check("rst_z_neg", z_neg, 64'd0);
`endif
      end else begin
        check("zin_ready", zin_ready, 64'(q.size() < DEPTH));
        check("beat_valid", beat_valid, 64'(q.size() > 0));
        if (q.size() > 0) begin
          exp_data = (half == 1) ? {32'd0, q[0].z[63:32]} : {32'd0, q[0].z[31:0]};
          check("beat_data", beat_data, exp_data);
          check("beat_sel", beat_sel, 64'(half));
          check("beat_last", beat_last, 64'((half == 1) || !q[0].wide));
        end
`ifdef Z_RESULT_FLAGS_EN
        check("z_zero", z_zero, 64'(m_zero));
        check("z_neg", z_neg, 64'(m_neg));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    @(negedge clk);
    check("lit_rst_ready", zin_ready, 64'd1);
    check("lit_rst_valid", beat_valid, 64'd0);
    cyc();
    clr = 1'b1;

    // Single add: one LO beat the cycle after the push
    zin_valid = 1'b1; z_in = 64'h0000_0000_0000_0007; opcode = 5'b00011;
    cyc();
    zin_valid = 1'b0;
    @(negedge clk);
    check("lit_add_valid", beat_valid, 64'd1);
    check("lit_add_data", beat_data, 64'h7);
    check("lit_add_sel", beat_sel, 64'd0);
    check("lit_add_last", beat_last, 64'd1);
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    @(negedge clk);
    check("lit_add_drained", beat_valid, 64'd0);

    // mul: LO then HI
    zin_valid = 1'b1; z_in = 64'h0000_0001_FFFF_FFFE; opcode = 5'b01111;
    cyc();
    zin_valid = 1'b0;
    @(negedge clk);
    check("lit_mul_lo_data", beat_data, 64'hFFFF_FFFE);
    check("lit_mul_lo_sel", beat_sel, 64'd0);
    check("lit_mul_lo_last", beat_last, 64'd0);
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    @(negedge clk);
    check("lit_mul_hi_data", beat_data, 64'h1);
    check("lit_mul_hi_sel", beat_sel, 64'd1);
    check("lit_mul_hi_last", beat_last, 64'd1);
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;

    // Backpressure during the HI beat of a div, buffer fills
    zin_valid = 1'b1; z_in = 64'h1234_5678_9ABC_DEF0; opcode = 5'b10000;
    cyc();
    z_in = 64'h0000_0000_0000_0055; opcode = 5'b00011;
    cyc();
    z_in = 64'h0000_0000_0000_0099;
    @(negedge clk);
    check("lit_bp_full", zin_ready, 64'd0);
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("lit_bp_hi_data", beat_data, 64'h1234_5678);
      check("lit_bp_hi_sel", beat_sel, 64'd1);
      check("lit_bp_hi_last", beat_last, 64'd1);
      check("lit_bp_refused", zin_ready, 64'd0);
    end
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    @(negedge clk);
    check("lit_bp_ready_after_pop", zin_ready, 64'd1);
    check("lit_bp_next_head", beat_data, 64'h55);
    cyc();
    zin_valid = 1'b0;
    @(negedge clk);
    check("lit_bp_third_taken", zin_ready, 64'd0);
    beat_ready = 1'b1;
    repeat (3) cyc();
    beat_ready = 1'b0;
    @(negedge clk);
    check("lit_bp_drained", beat_valid, 64'd0);

    // Full throughput: alternating add/mul with the bus always ready
    beat_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      zin_valid = 1'b1;
      opcode    = (i % 2 == 1) ? 5'b01111 : 5'b00011;
      z_in      = {32'($urandom), 32'($urandom)};
      cyc();
    end
    zin_valid = 1'b0;
    repeat (10) cyc();
    beat_ready = 1'b0;

`ifdef Z_RESULT_FLAGS_EN
    zin_valid = 1'b1; z_in = 64'hDEAD_BEEF_0000_0000; opcode = 5'b00100;
    cyc();
    zin_valid = 1'b0;
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    @(negedge clk);
    check("lit_flag_sub_zero", z_zero, 64'd1);
    check("lit_flag_sub_neg", z_neg, 64'd0);
    zin_valid = 1'b1; z_in = 64'h8000_0000_0000_0000; opcode = 5'b01111;
    cyc();
    zin_valid = 1'b0;
    beat_ready = 1'b1; cyc(); cyc(); beat_ready = 1'b0;
    @(negedge clk);
    check("lit_flag_mul_zero", z_zero, 64'd0);
    check("lit_flag_mul_neg", z_neg, 64'd1);
`endif

    // Reset mid-stream with two results buffered, head in its HI beat
    zin_valid = 1'b1; z_in = 64'hAAAA_0001_BBBB_0002; opcode = 5'b01111;
    cyc();
    z_in = 64'h0000_0000_CCCC_0003; opcode = 5'b00011;
    cyc();
    zin_valid = 1'b0;
    beat_ready = 1'b1; cyc(); beat_ready = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    check("lit_midrst_ready", zin_ready, 64'd1);
    check("lit_midrst_valid", beat_valid, 64'd0);
    cyc();
    clr = 1'b1;
    beat_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("lit_no_stale", beat_valid, 64'd0);
    end
    cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      zin_valid  = ($urandom % 10) < 6;
      beat_ready = ($urandom % 10) < 7;
      opcode     = 5'($urandom_range(0, 18));
      sel        = int'($urandom % 8);
      case (sel)
        0:       z_in = 64'd0;
        1:       z_in = {32'($urandom), 32'd0};
        2:       z_in = {32'd0, 32'($urandom)};
        default: z_in = {32'($urandom), 32'($urandom)};
      endcase
      if ($urandom % 500 == 0) clr = 1'b0;
      cyc();
      clr = 1'b1;
    end
    zin_valid  = 1'b0;
    beat_ready = 1'b1;
    repeat (8) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
